reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised successor to the core's 16x32 single-write register file. Three asynchronous read ports (rn, rm, rs) and two write ports: port A for ALU writeback, port B for load writeback. Adds asynchronous reset of register contents and a per-register busy scoreboard for outstanding loads. Sits between decode (reads, scoreboard set) and the writeback stage (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, register address width; NREG = 2**ADDR_W registers (localparam)
RESET_VAL, 0, value loaded into every register on reset (DATA_W bits)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rn_addr  input  ADDR_W  read port N address
rm_addr  input  ADDR_W  read port M address
rs_addr  input  ADDR_W  read port S address
rn_data  output  DATA_W  read data N
rm_data  output  DATA_W  read data M
rs_data  output  DATA_W  read data S
rn_busy  output  1  scoreboard bit of rn_addr
rm_busy  output  1  scoreboard bit of rm_addr
rs_busy  output  1  scoreboard bit of rs_addr
wa_en  input  1  port A (ALU) write enable
wa_addr  input  ADDR_W  port A address
wa_data  input  DATA_W  port A data
wb_en  input  1  port B (load) write enable; also clears busy bit
wb_addr  input  ADDR_W  port B address
wb_data  input  DATA_W  port B data
sb_set_en  input  1  mark sb_set_addr busy (load issued)
sb_set_addr  input  ADDR_W  register to mark busy
sb_conflict  output  1  registered one-cycle pulse: set issued to an already-busy register

Behaviour:
- Reset: clk single clock; rst_n asynchronous, active-low. While rst_n=0: all registers = RESET_VAL, all busy bits = 0, sb_conflict = 0. Read outputs therefore show RESET_VAL and busy=0 combinationally during reset.
- Reads: combinational, zero latency; x_data = reg[x_addr], x_busy = busy[x_addr] (before the clock edge, subject to the bypass feature).
- Writes: registered on rising clk. wa_en writes wa_data to reg[wa_addr]; wb_en writes wb_data to reg[wb_addr].
- Same-address dual write (wa_en & wb_en & wa_addr==wb_addr): port A wins because it is the younger instruction. Register gets wa_data; busy bit is still cleared by port B.
- Different-address dual write: both take effect in the same cycle.
- Scoreboard next state per register i: busy[i] <= (sb_set_en & sb_set_addr==i) | (busy[i] & ~(wb_en & wb_addr==i)). Set and clear of the same register in the same cycle leaves it busy (set wins).
- A port A write does not change busy bits.
- sb_conflict <= sb_set_en & busy[sb_set_addr] & ~(wb_en & wb_addr==sb_set_addr). The busy value here is the current state. Pulse is one cycle, 0 otherwise. The set still takes effect.
- No register is hardwired; all NREG registers are writable.
- Reset asserted mid-operation: pending writes in that cycle are discarded, and state returns to the reset values immediately.

Optional Feature:
REG_FILE_BYPASS_EN
- Defined: write-to-read forwarding. If a read address matches an enabled write in the same cycle, x_data returns the incoming write data. Port A has priority over port B, matching the same-address write rule. x_busy returns 0 when wb_en matches that address and no sb_set to that address occurs in the same cycle.
- Not defined: reads return the pre-edge register and busy contents; new values are visible the cycle after the write.

Test Plan:
- Reset: DATA_W=32, RESET_VAL=0. Assert rst_n=0 asynchronously mid-cycle after writing 0xDEADBEEF to r5 -> rn_data(addr5)=0 immediately; all busy=0; sb_conflict=0.
- Dual write, different addresses: wa r3=0x11111111 and wb r7=0x22222222 in one cycle -> next cycle rn(3)=0x11111111, rm(7)=0x22222222.
- Dual write, same address r9: wa_data=0xAAAA0000, wb_data=0x0000BBBB, r9 busy -> next cycle r9=0xAAAA0000, busy[9]=0.
- Scoreboard: sb_set r4 -> rn_busy(4)=1 next cycle. Second sb_set r4 -> sb_conflict=1 for exactly one cycle. wb_en r4 -> busy clears. Set and clear of r4 in the same cycle -> busy stays 1, no conflict.
- Bypass with REG_FILE_BYPASS_EN defined: wa r2=0x12345678 while rs_addr=2 -> rs_data=0x12345678 in the same cycle. Without the macro -> old value, new value next cycle.
- Parametrisation: DATA_W=16, ADDR_W=3, RESET_VAL=16'h5A5A -> after reset all 8 registers read 0x5A5A; writes to r7 work and wrap-free addressing is verified.

Source files
------------

// File: rtl/reg_file_sb.sv
// Multi-port register file with load scoreboard: 3 async read ports, ALU (A) and load (B) write ports.
// Optional REG_FILE_BYPASS_EN forwards same-cycle write data/busy-clear to the read ports.
module reg_file_sb_cell #(
  parameter int          DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] wd,
  input  logic              set,
  input  logic              clr,
  output logic [DATA_W-1:0] q,
  output logic              busy
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= RESET_VAL;
      busy <= 1'b0;
    end else begin
      if (we) q <= wd;
      busy <= set | (busy & ~clr);
    end
  end
endmodule

module reg_file_sb #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rn_addr,
  input  logic [ADDR_W-1:0] rm_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  output logic [DATA_W-1:0] rn_data,
  output logic [DATA_W-1:0] rm_data,
  output logic [DATA_W-1:0] rs_data,
  output logic              rn_busy,
  output logic              rm_busy,
  output logic              rs_busy,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              sb_set_en,
  input  logic [ADDR_W-1:0] sb_set_addr,
  output logic              sb_conflict
);
  localparam int NREG = 2**ADDR_W;
  localparam int NRD  = 3;

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0]             busy;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    logic hit_a, hit_b;
    assign hit_a = wa_en && (wa_addr == ADDR_W'(i));
    assign hit_b = wb_en && (wb_addr == ADDR_W'(i));
    // port A is the younger instruction, so its data wins; port B still retires the load
    reg_file_sb_cell #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (hit_a | hit_b),
      .wd   (hit_a ? wa_data : wb_data),
      .set  (sb_set_en && (sb_set_addr == ADDR_W'(i))),
      .clr  (hit_b),
      .q    (regs[i]),
      .busy (busy[i])
    );
  end

  logic [ADDR_W-1:0] rd_addr [NRD];
  logic [DATA_W-1:0] rd_data [NRD];
  logic              rd_busy [NRD];

  assign rd_addr[0] = rn_addr;
  assign rd_addr[1] = rm_addr;
  assign rd_addr[2] = rs_addr;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    always_comb begin
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy[rd_addr[p]];
`ifdef REG_FILE_BYPASS_EN
      if (wb_en && (wb_addr == rd_addr[p])) begin
        rd_data[p] = wb_data;
        if (!(sb_set_en && (sb_set_addr == rd_addr[p]))) rd_busy[p] = 1'b0;
      end
      if (wa_en && (wa_addr == rd_addr[p])) rd_data[p] = wa_data;
`endif
    end
  end

  assign rn_data = rd_data[0];
  assign rm_data = rd_data[1];
  assign rs_data = rd_data[2];
  assign rn_busy = rd_busy[0];
  assign rm_busy = rd_busy[1];
  assign rs_busy = rd_busy[2];

  // a load retiring to the same register this cycle frees it, so that is not a conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_conflict <= 1'b0;
    else        sb_conflict <= sb_set_en & busy[sb_set_addr] & ~(wb_en && (wb_addr == sb_set_addr));
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: vector table plus reset, bypass and narrow-parameter sequences.
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rn_addr, rm_addr, rs_addr, wa_addr, wb_addr, sb_set_addr;
  logic [31:0] rn_data, rm_data, rs_data, wa_data, wb_data;
  logic        rn_busy, rm_busy, rs_busy, wa_en, wb_en, sb_set_en, sb_conflict;

  reg_file_sb u_dut (
    .clk(clk), .rst_n(rst_n),
    .rn_addr(rn_addr), .rm_addr(rm_addr), .rs_addr(rs_addr),
    .rn_data(rn_data), .rm_data(rm_data), .rs_data(rs_data),
    .rn_busy(rn_busy), .rm_busy(rm_busy), .rs_busy(rs_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_conflict(sb_conflict)
  );

  logic [2:0]  p_rn_addr, p_rm_addr, p_rs_addr, p_wa_addr, p_wb_addr, p_sb_addr;
  logic [15:0] p_rn_data, p_rm_data, p_rs_data, p_wa_data, p_wb_data;
  logic        p_rn_busy, p_rm_busy, p_rs_busy, p_wa_en, p_wb_en, p_sb_en, p_conflict;

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .RESET_VAL(16'h5A5A)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .rn_addr(p_rn_addr), .rm_addr(p_rm_addr), .rs_addr(p_rs_addr),
    .rn_data(p_rn_data), .rm_data(p_rm_data), .rs_data(p_rs_data),
    .rn_busy(p_rn_busy), .rm_busy(p_rm_busy), .rs_busy(p_rs_busy),
    .wa_en(p_wa_en), .wa_addr(p_wa_addr), .wa_data(p_wa_data),
    .wb_en(p_wb_en), .wb_addr(p_wb_addr), .wb_data(p_wb_data),
    .sb_set_en(p_sb_en), .sb_set_addr(p_sb_addr), .sb_conflict(p_conflict)
  );

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wa_en;  logic [3:0] wa_addr; logic [31:0] wa_data;
    logic        wb_en;  logic [3:0] wb_addr; logic [31:0] wb_data;
    logic        sb_en;  logic [3:0] sb_addr;
    logic [3:0]  rn, rm, rs;
    logic [31:0] e_rn, e_rm, e_rs;
    logic [2:0]  e_busy;   // {rn,rm,rs}
    logic        e_conf;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  task automatic idle();
    wa_en = 0; wb_en = 0; sb_set_en = 0;
    wa_addr = 0; wb_addr = 0; sb_set_addr = 0; wa_data = 0; wb_data = 0;
  endtask

  initial begin
    //        waE wa   wa_data        wbE wb   wb_data        sbE sb   rn    rm    rs    e_rn           e_rm           e_rs           busy    conf
    vec[0]  = '{1, 4'd3, 32'h11111111, 1, 4'd7, 32'h22222222, 0, 4'd0, 4'd3, 4'd7, 4'd0, 32'h11111111, 32'h22222222, 32'h0,        3'b000, 0};
    vec[1]  = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,        1, 4'd9, 4'd9, 4'd3, 4'd7, 32'h0,        32'h11111111, 32'h22222222, 3'b100, 0};
    vec[2]  = '{1, 4'd9, 32'hAAAA0000, 1, 4'd9, 32'h0000BBBB, 0, 4'd0, 4'd9, 4'd0, 4'd0, 32'hAAAA0000, 32'h0,        32'h0,        3'b000, 0};
    vec[3]  = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,        1, 4'd4, 4'd4, 4'd9, 4'd0, 32'h0,        32'hAAAA0000, 32'h0,        3'b100, 0};
    vec[4]  = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,        1, 4'd4, 4'd4, 4'd9, 4'd0, 32'h0,        32'hAAAA0000, 32'h0,        3'b100, 1};
    vec[5]  = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,        0, 4'd0, 4'd4, 4'd9, 4'd0, 32'h0,        32'hAAAA0000, 32'h0,        3'b100, 0};
    vec[6]  = '{0, 4'd0, 32'h0,        1, 4'd4, 32'h44444444, 0, 4'd0, 4'd4, 4'd9, 4'd0, 32'h44444444, 32'hAAAA0000, 32'h0,        3'b000, 0};
    vec[7]  = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,        1, 4'd4, 4'd4, 4'd9, 4'd0, 32'h44444444, 32'hAAAA0000, 32'h0,        3'b100, 0};
    vec[8]  = '{0, 4'd0, 32'h0,        1, 4'd4, 32'h55555555, 1, 4'd4, 4'd4, 4'd9, 4'd0, 32'h55555555, 32'hAAAA0000, 32'h0,        3'b100, 0};
    vec[9]  = '{0, 4'd0, 32'h0,        1, 4'd4, 32'h66666666, 0, 4'd0, 4'd4, 4'd9, 4'd0, 32'h66666666, 32'hAAAA0000, 32'h0,        3'b000, 0};
    vec[10] = '{1, 4'd15,32'hFFFFFFFF, 0, 4'd0, 32'h0,        0, 4'd0, 4'd0, 4'd0, 4'd15,32'h0,        32'h0,        32'hFFFFFFFF, 3'b000, 0};
    vec[11] = '{1, 4'd15,32'h00000001, 0, 4'd0, 32'h0,        1, 4'd15,4'd15,4'd0, 4'd15,32'h1,        32'h0,        32'h1,        3'b101, 0};
    vec[12] = '{1, 4'd15,32'h00000002, 0, 4'd0, 32'h0,        0, 4'd0, 4'd15,4'd0, 4'd15,32'h2,        32'h0,        32'h2,        3'b101, 0};
    vec[13] = '{0, 4'd0, 32'h0,        1, 4'd15,32'h00000003, 1, 4'd2, 4'd15,4'd2, 4'd4, 32'h3,        32'h0,        32'h66666666, 3'b010, 0};

    idle();
    rn_addr = 0; rm_addr = 0; rs_addr = 0;
    p_wa_en = 0; p_wb_en = 0; p_sb_en = 0;
    p_wa_addr = 0; p_wb_addr = 0; p_sb_addr = 0; p_wa_data = 0; p_wb_data = 0;
    p_rn_addr = 0; p_rm_addr = 0; p_rs_addr = 0;

    #1;
    chk("rst_rn_data", rn_data, 32'h0);
    chk("rst_busy", {29'd0, rn_busy, rm_busy, rs_busy}, 32'h0);
    chk("rst_conflict", {31'd0, sb_conflict}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // narrow instance: reset value, write r7, no aliasing onto other registers
    for (int i = 0; i < 8; i++) begin
      p_rn_addr = 3'(i); #1;
      chk($sformatf("p16_rst_r%0d", i), {16'd0, p_rn_data}, 32'h5A5A);
    end
    @(negedge clk);
    p_wa_en = 1; p_wa_addr = 3'd7; p_wa_data = 16'hBEEF;
    @(posedge clk); #1 p_wa_en = 0;
    p_rs_addr = 3'd7; #1;
    chk("p16_r7", {16'd0, p_rs_data}, 32'hBEEF);
    for (int i = 0; i < 7; i++) begin
      p_rm_addr = 3'(i); #1;
      chk($sformatf("p16_keep_r%0d", i), {16'd0, p_rm_data}, 32'h5A5A);
    end

    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      wa_en = vec[v].wa_en; wa_addr = vec[v].wa_addr; wa_data = vec[v].wa_data;
      wb_en = vec[v].wb_en; wb_addr = vec[v].wb_addr; wb_data = vec[v].wb_data;
      sb_set_en = vec[v].sb_en; sb_set_addr = vec[v].sb_addr;
      rn_addr = vec[v].rn; rm_addr = vec[v].rm; rs_addr = vec[v].rs;
      @(posedge clk); #1 idle(); #1;
      chk($sformatf("v%0d_rn", v), rn_data, vec[v].e_rn);
      chk($sformatf("v%0d_rm", v), rm_data, vec[v].e_rm);
      chk($sformatf("v%0d_rs", v), rs_data, vec[v].e_rs);
      chk($sformatf("v%0d_busy", v), {29'd0, rn_busy, rm_busy, rs_busy}, {29'd0, vec[v].e_busy});
      chk($sformatf("v%0d_conf", v), {31'd0, sb_conflict}, {31'd0, vec[v].e_conf});
    end

    // mid-cycle reset with conflict pulse high and a write pending
    @(negedge clk);
    wa_en = 1; wa_addr = 4'd5; wa_data = 32'hDEADBEEF;
    @(posedge clk); #1 idle();
    rn_addr = 4'd5; rm_addr = 4'd1; rs_addr = 4'd3; #1;
    chk("pre_rst_r5", rn_data, 32'hDEADBEEF);
    repeat (2) begin
      @(negedge clk); sb_set_en = 1; sb_set_addr = 4'd1;
    end
    @(posedge clk); #2;
    chk("pre_rst_conf", {31'd0, sb_conflict}, 32'h1);
    wa_en = 1; wa_addr = 4'd5; wa_data = 32'h00001234;
    rst_n = 1'b0; #1;
    chk("mid_rst_r5", rn_data, 32'h0);
    chk("mid_rst_r3", rs_data, 32'h0);
    chk("mid_rst_busy", {29'd0, rn_busy, rm_busy, rs_busy}, 32'h0);
    chk("mid_rst_conf", {31'd0, sb_conflict}, 32'h0);
    @(posedge clk); #1;
    chk("rst_discard_r5", rn_data, 32'h0);
    chk("rst_hold_busy", {31'd0, rm_busy}, 32'h0);
    @(negedge clk); idle(); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_r5", rn_data, 32'h0);
    chk("post_rst_conf", {31'd0, sb_conflict}, 32'h0);

    // same-cycle read of a write in flight
    @(negedge clk);
    rs_addr = 4'd2; wa_en = 1; wa_addr = 4'd2; wa_data = 32'h12345678; #1;
    chk("byp_rs_same", rs_data, BYP ? 32'h12345678 : 32'h0);
    @(posedge clk); #1 idle(); #1;
    chk("byp_rs_next", rs_data, 32'h12345678);

    @(negedge clk); sb_set_en = 1; sb_set_addr = 4'd6;
    @(posedge clk); #1 idle();
    @(negedge clk);
    rn_addr = 4'd6;
    wa_en = 1; wa_addr = 4'd6; wa_data = 32'h88888888;
    wb_en = 1; wb_addr = 4'd6; wb_data = 32'h77777777; #1;
    chk("byp_busy_same", {31'd0, rn_busy}, BYP ? 32'h0 : 32'h1);
    chk("byp_prio_same", rn_data, BYP ? 32'h88888888 : 32'h0);
    @(posedge clk); #1 idle(); #1;
    chk("byp_prio_next", rn_data, 32'h88888888);
    chk("byp_busy_next", {31'd0, rn_busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
